// File: rtl/encoder_scheduler_if.sv
// Request/response bundle between the weight-load requesters and encoder_scheduler.
// slave = scheduler side, master = requester/consumer side.
interface encoder_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int NIB     = 8
);
   localparam int DW  = 4 * NIB;
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid_i;
   logic [NUM_REQ-1:0]    req_ready_o;
   logic [NUM_REQ*DW-1:0] req_data_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [DW-1:0]         rsp_data_o;
   logic [IDW-1:0]        rsp_id_o;

   modport slave (
      input  req_valid_i, req_data_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o
   );

   modport master (
      output req_valid_i, req_data_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o
   );
endinterface

// File: rtl/encoder_scheduler.sv
// Round-robin scheduler sharing one nibble quantizer among NUM_REQ requesters.
// Optional ENC_SCHED_PERF_EN adds a 32-bit response handshake counter (rsp_count_o).

module encoder (
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);
   always_comb begin
      o_nib = 4'h0;
      case (i_nib)
         4'h0: o_nib = 4'h0;
         4'h1: o_nib = 4'h1;
         4'h2: o_nib = 4'h1;
         4'h3: o_nib = 4'h2;
         4'h4: o_nib = 4'h2;
         4'h5: o_nib = 4'h3;
         4'h6: o_nib = 4'h3;
         4'h7: o_nib = 4'h4;
         4'h8: o_nib = 4'hC;
         4'h9: o_nib = 4'hB;
         4'hA: o_nib = 4'hB;
         4'hB: o_nib = 4'hA;
         4'hC: o_nib = 4'hA;
         4'hD: o_nib = 4'h9;
         4'hE: o_nib = 4'h9;
         4'hF: o_nib = 4'h0;
         default: o_nib = 4'h0;
      endcase
   end
endmodule

// state | meaning
// IDLE  | waiting for any request; grants RR winner combinationally
// ENC   | streaming latched word through encoder, one nibble per cycle
// RESP  | quantized word presented until rsp_ready_i
module encoder_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int NIB     = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   encoder_scheduler_if.slave  bus,
   output logic                busy_o
`ifdef ENC_SCHED_PERF_EN
   ,
   output logic [31:0]         rsp_count_o
`endif
);
   localparam int DW  = 4 * NIB;
   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ENC, S_RESP} state_t;

   state_t             r_state, w_state_nxt;
   logic [IDW-1:0]     r_ptr, r_id, w_win;
   logic               w_found, w_accept;
   logic [NUM_REQ-1:0] w_ready;
   logic [DW-1:0]      r_data, r_result;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic [3:0]         w_nib_in, w_nib_out;

   always_comb begin
      int k;
      k       = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = int'(r_ptr) + i;
         if (k >= NUM_REQ) k = k - NUM_REQ;
         if (!w_found && bus.req_valid_i[k]) begin
            w_found = 1'b1;
            w_win   = IDW'(k);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // rst_ni gates the grant so no requester sees ready while reset is held
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = '0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found && rst_ni) begin
               w_accept       = 1'b1;
               w_ready[w_win] = 1'b1;
               w_state_nxt    = S_ENC;
            end
         end
         S_ENC: begin
            if (r_cnt == CW'(NIB - 1)) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_nib_in = r_data[r_cnt*4 +: 4];

   encoder u_encoder (
      .i_nib (w_nib_in),
      .o_nib (w_nib_out)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr    <= '0;
         r_id     <= '0;
         r_data   <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         if (w_accept) begin
            r_data <= bus.req_data_i[w_win*DW +: DW];
            r_id   <= w_win;
            r_cnt  <= '0;
            r_ptr  <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
         end else if (r_state == S_ENC) begin
            r_result[r_cnt*4 +: 4] <= w_nib_out;
            r_cnt                  <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.req_ready_o = w_ready;
   assign bus.rsp_valid_o = (r_state == S_RESP);
   assign bus.rsp_data_o  = r_result;
   assign bus.rsp_id_o    = r_id;
   assign busy_o          = r_busy;

`ifdef ENC_SCHED_PERF_EN
   logic [31:0] r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                   r_count <= '0;
      else if (r_state == S_RESP && bus.rsp_ready_i) r_count <= r_count + 32'd1;
   end

   assign rsp_count_o = r_count;
`endif

endmodule
